// File: rtl/snake_game_fsm.sv
`default_nettype none
// =============================================================================
// snake_game_fsm: snake game core state machine on a 16x16 wrapping grid
// Revision: 1.0 - initial release
// =============================================================================
module snake_game_fsm #(
  parameter int         MAX_LEN   = 16,
  parameter int         LEN_W     = 5,
  parameter int         START_LEN = 3,
  parameter logic [7:0] FOOD_INIT = 8'h3C,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                   board_clk,
  input  logic                   reset,
  input  logic                   game_tick,
  input  logic                   btn_u,
  input  logic                   btn_d,
  input  logic                   btn_l,
  input  logic                   btn_r,
  input  logic                   start_ack,
  output logic                   Qi,
  output logic                   Qm,
  output logic                   Qc,
  output logic                   Qh,
  output logic                   Qe,
  output logic                   Qw,
  output logic                   Ql,
  output logic                   Qu,
  output logic [7:0]             food,
  output logic [LEN_W-1:0]       length,
  output logic [MAX_LEN*8-1:0]   locations
);

  localparam logic [7:0] S_INIT = 8'b0000_0001;
  localparam logic [7:0] S_MOVE = 8'b0000_0010;
  localparam logic [7:0] S_COMP = 8'b0000_0100;
  localparam logic [7:0] S_HIT  = 8'b0000_1000;
  localparam logic [7:0] S_EAT  = 8'b0001_0000;
  localparam logic [7:0] S_WIN  = 8'b0010_0000;
  localparam logic [7:0] S_LOSE = 8'b0100_0000;
  localparam logic [7:0] S_UPD  = 8'b1000_0000;

  // Encoding chosen so that the reverse of any direction is dir ^ 1
  localparam logic [1:0] DIR_U = 2'd0;
  localparam logic [1:0] DIR_D = 2'd1;
  localparam logic [1:0] DIR_L = 2'd2;
  localparam logic [1:0] DIR_R = 2'd3;

  localparam logic [LEN_W-1:0] START_LEN_L = LEN_W'(START_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_L   = LEN_W'(MAX_LEN);

  logic [7:0]       state_q, state_d;
  logic [1:0]       dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic [7:0]       next_head_q, next_head_d;
  logic [7:0]       food_q, food_d, lfsr_q, lfsr_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic             grow_q, grow_d;
  logic [7:0]       seg_q [MAX_LEN];
  logic [7:0]       seg_d [MAX_LEN];
  logic             btn_valid, eat, hit, cand_used;
  logic [1:0]       btn_dir;

  function automatic logic [7:0] seg_init(input int i);
    return (i < START_LEN) ? 8'h88 - 8'(i) : 8'hFF;
  endfunction

  function automatic logic [7:0] step_pos(input logic [7:0] p, input logic [1:0] d);
    logic [3:0] x, y;
    x = p[3:0];
    y = p[7:4];
    case (d)
      DIR_U:   y = y - 4'd1;
      DIR_D:   y = y + 4'd1;
      DIR_L:   x = x - 4'd1;
      default: x = x + 4'd1;
    endcase
    return {y, x};
  endfunction

  always_comb begin
    btn_valid = 1'b1;
    btn_dir   = DIR_R;
    if (btn_u)      btn_dir = DIR_U;
    else if (btn_d) btn_dir = DIR_D;
    else if (btn_l) btn_dir = DIR_L;
    else if (btn_r) btn_dir = DIR_R;
    else            btn_valid = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    pend_dir_d  = pend_dir_q;
    next_head_d = next_head_q;
    food_d      = food_q;
    length_d    = length_q;
    grow_d      = grow_q;
    seg_d       = seg_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    eat         = (next_head_q == food_q);
    hit         = 1'b0;
    cand_used   = 1'b0;
    // The tail cell only counts as occupied when the snake is about to grow
    for (int i = 0; i < MAX_LEN; i++) begin
      if (seg_q[i] == next_head_q) begin
        if (LEN_W'(i) + LEN_W'(1) < length_q) hit = 1'b1;
        if (eat && (LEN_W'(i) + LEN_W'(1) == length_q)) hit = 1'b1;
      end
      if ((LEN_W'(i) < length_q) && (seg_q[i] == lfsr_q)) cand_used = 1'b1;
    end

    case (state_q)
      S_INIT: if (start_ack) state_d = S_MOVE;
      S_MOVE: begin
        if (btn_valid && (btn_dir != (dir_q ^ 2'b01))) pend_dir_d = btn_dir;
        if (game_tick) state_d = S_COMP;
      end
      S_COMP: begin
        dir_d       = pend_dir_q;
        next_head_d = step_pos(seg_q[0], pend_dir_q);
        state_d     = S_HIT;
      end
      S_HIT: begin
        if (hit) begin
          state_d = S_LOSE;
        end else begin
          grow_d  = eat;
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        for (int i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i-1];
        seg_d[0] = next_head_q;
        if (grow_q) begin
          length_d = length_q + LEN_W'(1);
          state_d  = (length_q + LEN_W'(1) == MAX_LEN_L) ? S_WIN : S_EAT;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_EAT: begin
        if (!cand_used) begin
          food_d  = lfsr_q;
          state_d = S_MOVE;
        end
      end
      S_WIN, S_LOSE: begin
        if (start_ack) begin
          state_d     = S_INIT;
          dir_d       = DIR_R;
          pend_dir_d  = DIR_R;
          next_head_d = 8'h00;
          food_d      = FOOD_INIT;
          length_d    = START_LEN_L;
          grow_d      = 1'b0;
          for (int i = 0; i < MAX_LEN; i++) seg_d[i] = seg_init(i);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      state_q     <= S_INIT;
      dir_q       <= DIR_R;
      pend_dir_q  <= DIR_R;
      next_head_q <= 8'h00;
      food_q      <= FOOD_INIT;
      lfsr_q      <= LFSR_SEED;
      length_q    <= START_LEN_L;
      grow_q      <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= seg_init(i);
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pend_dir_q  <= pend_dir_d;
      next_head_q <= next_head_d;
      food_q      <= food_d;
      lfsr_q      <= lfsr_d;
      length_q    <= length_d;
      grow_q      <= grow_d;
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign Qi     = state_q[0];
  assign Qm     = state_q[1];
  assign Qc     = state_q[2];
  assign Qh     = state_q[3];
  assign Qe     = state_q[4];
  assign Qw     = state_q[5];
  assign Ql     = state_q[6];
  assign Qu     = state_q[7];
  assign food   = food_q;
  assign length = length_q;

  generate
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_loc
      assign locations[8*g +: 8] = seg_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_snake_game_fsm.sv
`default_nettype none
// tb_snake_game_fsm: random play checked by a list-based snake model through a scoreboard,
// plus directed win/self-collision runs on two small instances.
module tb_snake_game_fsm;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic board_clk = 1'b0;
  logic reset = 1'b1;
  logic game_tick = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, start_ack = 1'b0;
  logic Qi, Qm, Qc, Qh, Qe, Qw, Ql, Qu;
  logic [7:0] food;
  logic [LEN_W-1:0] length;
  logic [MAX_LEN*8-1:0] locations;

  logic x_tick = 1'b0, x_u = 1'b0, x_d = 1'b0, x_l = 1'b0, x_r = 1'b0, x_ack = 1'b0;
  logic wi, wm, wc, wh, we, ww, wl, wu;
  logic [7:0] w_food;
  logic [2:0] w_len;
  logic [31:0] w_loc;
  logic ci, cm, cc, ch, ce, cw, cl, cu;
  logic [7:0] c_food;
  logic [4:0] c_len;
  logic [127:0] c_loc;

  snake_game_fsm dut (
    .board_clk(board_clk), .reset(reset), .game_tick(game_tick),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .start_ack(start_ack),
    .Qi(Qi), .Qm(Qm), .Qc(Qc), .Qh(Qh), .Qe(Qe), .Qw(Qw), .Ql(Ql), .Qu(Qu),
    .food(food), .length(length), .locations(locations)
  );

  snake_game_fsm #(.MAX_LEN(4), .LEN_W(3), .FOOD_INIT(8'h89)) dut_w (
    .board_clk(board_clk), .reset(reset), .game_tick(x_tick),
    .btn_u(x_u), .btn_d(x_d), .btn_l(x_l), .btn_r(x_r), .start_ack(x_ack),
    .Qi(wi), .Qm(wm), .Qc(wc), .Qh(wh), .Qe(we), .Qw(ww), .Ql(wl), .Qu(wu),
    .food(w_food), .length(w_len), .locations(w_loc)
  );

  snake_game_fsm #(.START_LEN(5)) dut_c (
    .board_clk(board_clk), .reset(reset), .game_tick(x_tick),
    .btn_u(x_u), .btn_d(x_d), .btn_l(x_l), .btn_r(x_r), .start_ack(x_ack),
    .Qi(ci), .Qm(cm), .Qc(cc), .Qh(ch), .Qe(ce), .Qw(cw), .Ql(cl), .Qu(cu),
    .food(c_food), .length(c_len), .locations(c_loc)
  );

  always #5 board_clk = ~board_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge board_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [7:0] m_lfsr;
  always @(posedge board_clk) m_lfsr <= reset ? 8'hA5 : lfsr_next(m_lfsr);

  typedef struct {
    int           kind;   // 0 move-wait, 1 win, 2 lose
    int           when;
    int           len;
    logic [7:0]   food;
    logic [127:0] locs;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] body[$];   // head first, exactly mlen entries
  int         mlen, mdir, mpend, mkind;
  logic [7:0] mfood;
  bit         mterm;

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit in_body(input logic [7:0] v);
    for (int i = 0; i < mlen; i++) if (body[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    body = '{8'h88, 8'h87, 8'h86};
    mlen = 3; mdir = 3; mpend = 3; mfood = 8'h3C; mterm = 1'b0; mkind = 0;
  endtask

  // b = {up, down, left, right}
  task automatic model_buttons(input logic [3:0] b);
    int c;
    c = -1;
    if (b[3]) c = 0; else if (b[2]) c = 1; else if (b[1]) c = 2; else if (b[0]) c = 3;
    if (c >= 0 && c != opposite(mdir)) mpend = c;
  endtask

  task automatic predict(input int n);
    exp_t e;
    logic [7:0] h, nh, cand;
    int x, y, limit, k;
    bit eat, hit;
    mdir = mpend;
    h = body[0];
    x = int'(h[3:0]);
    y = int'(h[7:4]);
    case (mdir)
      0: y = (y + 15) % 16;
      1: y = (y + 1) % 16;
      2: x = (x + 15) % 16;
      default: x = (x + 1) % 16;
    endcase
    nh = 8'(y * 16 + x);
    eat = (nh == mfood);
    limit = eat ? mlen : mlen - 1;
    hit = 1'b0;
    for (int i = 0; i < limit; i++) if (body[i] == nh) hit = 1'b1;
    if (hit) begin
      e.kind = 2; e.when = n + 3; mterm = 1'b1; mkind = 2;
    end else begin
      body.push_front(nh);
      if (eat) mlen++;
      else void'(body.pop_back());
      if (eat && mlen == MAX_LEN) begin
        e.kind = 1; e.when = n + 4; mterm = 1'b1; mkind = 1;
      end else if (eat) begin
        cand = m_lfsr;
        repeat (4) cand = lfsr_next(cand);
        k = 4;
        while (in_body(cand) && k < 600) begin
          cand = lfsr_next(cand);
          k++;
        end
        mfood = cand;
        e.kind = 0; e.when = n + k + 1;
      end else begin
        e.kind = 0; e.when = n + 4;
      end
    end
    e.len = mlen;
    e.food = mfood;
    e.locs = '0;
    for (int i = 0; i < mlen; i++) e.locs[8*i +: 8] = body[i];
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [7:0]   prev, cur;
    logic [127:0] mask;
    exp_t         e;
    int           kind;
    prev = '0;
    forever begin
      @(negedge board_clk);
      cur = {Qu, Ql, Qw, Qe, Qh, Qc, Qm, Qi};
      if (!reset) begin
        check("onehot", 128'($countones(cur)), 128'd1);
        if ((Qm || Qw || Ql) && (prev[2] || prev[3] || prev[4] || prev[7])) begin
          kind = Qm ? 0 : (Qw ? 1 : 2);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got state %0h with no move outstanding", cur);
          end else begin
            e = sb.pop_front();
            mask = '0;
            for (int i = 0; i < e.len; i++) mask[8*i +: 8] = 8'hFF;
            check("end_state", 128'(kind), 128'(e.kind));
            check("latency", 128'(cyc), 128'(e.when));
            check("length", 128'(length), 128'(e.len));
            check("food", 128'(food), 128'(e.food));
            check("body", locations & mask, e.locs);
          end
        end
      end
      prev = cur;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input logic [3:0] b, input logic t, input logic a);
    @(negedge board_clk);
    {btn_u, btn_d, btn_l, btn_r} = b;
    game_tick = t;
    start_ack = a;
  endtask

  task automatic xpulse(input logic [3:0] b, input logic t, input logic a);
    @(negedge board_clk);
    {x_u, x_d, x_l, x_r} = b;
    x_tick = t;
    x_ack = a;
  endtask

  task automatic settle();
    for (int k = 0; k < 300; k++) begin
      pulse(4'b0000, 1'b0, 1'b0);
      if (Qm || Ql || Qw) return;
    end
    checks++;
    failures++;
    $display("FAIL settle_timeout: got no Qm/Qw/Ql within 300 cycles, required one");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_qi"}, 128'(Qi), 128'd1);
    check({tag, "_len"}, 128'(length), 128'd3);
    check({tag, "_loc"}, 128'(locations[23:0]), 128'h868788);
    check({tag, "_loc_hi"}, 128'(locations[127:24]), {24'd0, {104{1'b1}}});
    check({tag, "_food"}, 128'(food), 128'h3C);
  endtask

  task automatic terminal();
    pulse(4'b1000, 1'b1, 1'b0);
    pulse(4'b0000, 1'b0, 1'b0);
    check("term_hold", 128'({Qw, Ql}), (mkind == 1) ? 128'b10 : 128'b01);
    pulse(4'b0000, 1'b0, 1'b1);
    pulse(4'b0000, 1'b0, 1'b0);
    check_reset_values("restart");
    model_reset();
    pulse(4'b0000, 1'b1, 1'b0);
    pulse(4'b0000, 1'b0, 1'b1);
    pulse(4'b0000, 1'b0, 1'b0);
    check("restart_qm", 128'(Qm), 128'd1);
  endtask

  task automatic press(input logic [3:0] b);
    pulse(b, 1'b0, 1'b0);
    model_buttons(b);
  endtask

  task automatic move(input logic [3:0] b);
    pulse(b, 1'b1, 1'b0);
    model_buttons(b);
    predict(cyc);
    pulse(4'($urandom_range(0, 15)), 1'b1, 1'b0);   // lands in Qc: dropped
    settle();
    if (mterm) terminal();
  endtask

  function automatic logic [3:0] toward_food();
    logic [7:0] h;
    logic [3:0] ddx, ddy;
    h = body[0];
    ddx = mfood[3:0] - h[3:0];
    ddy = mfood[7:4] - h[7:4];
    if (ddx != 4'd0) return (ddx < 4'd8) ? 4'b0001 : 4'b0010;
    if (ddy != 4'd0) return (ddy < 4'd8) ? 4'b0100 : 4'b1000;
    return 4'b0000;
  endfunction

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    logic [3:0] b;
    model_reset();
    repeat (3) @(negedge board_clk);
    check_reset_values("reset");
    reset = 1'b0;

    pulse(4'b1000, 1'b1, 1'b0);
    pulse(4'b0000, 1'b0, 1'b0);
    check("qi_ignores", 128'({Qi, Qm}), 128'b10);
    pulse(4'b0000, 1'b0, 1'b1);
    pulse(4'b0000, 1'b0, 1'b0);
    check("start_qm", 128'(Qm), 128'd1);

    move(4'b0000);
    check("first_move", 128'(locations[23:0]), 128'h878889);
    check("first_len", 128'(length), 128'd3);
    press(4'b0010);
    move(4'b0000);
    check("reverse_ignored", 128'(locations[7:0]), 128'h8A);
    move(4'b1001);
    check("up_beats_right", 128'(locations[7:0]), 128'h7A);
    repeat (5) move(4'b0001);
    check("x_edge", 128'(locations[7:0]), 128'h7F);
    move(4'b0001);
    check("x_wrap", 128'(locations[7:0]), 128'h70);
    repeat (7) move(4'b1000);
    check("y_edge", 128'(locations[7:0]), 128'h00);
    move(4'b1000);
    check("y_wrap", 128'(locations[7:0]), 128'hF0);
    repeat (12) move(4'b1000);
    repeat (12) move(4'b0001);
    check("eat_head", 128'(locations[7:0]), 128'h3C);
    check("eat_len", 128'(length), 128'd4);
    ok = 1'b1;
    for (int i = 0; i < int'(length); i++) if (locations[8*i +: 8] == food) ok = 1'b0;
    check("food_free", 128'(ok), 128'd1);

    for (int m = 0; m < 250; m++) begin
      if ($urandom_range(0, 9) < 6) b = toward_food();
      else b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) press(4'($urandom_range(0, 15)));
      move(b);
    end

    // reset while a move is in flight
    pulse(4'b0000, 1'b1, 1'b0);
    pulse(4'b0000, 1'b0, 1'b0);
    @(negedge board_clk);
    sb.delete();
    reset = 1'b1;
    @(negedge board_clk);
    check_reset_values("midreset");
    reset = 1'b0;
    model_reset();
    pulse(4'b0000, 1'b0, 1'b1);
    pulse(4'b0000, 1'b0, 1'b0);
    move(4'b0000);
    check("after_reset_move", 128'(locations[23:0]), 128'h878889);

    // small instances: win at MAX_LEN=4, self-collision at START_LEN=5
    check("c_reset_loc", 128'(c_loc[39:0]), 128'h8485868788);
    check("c_reset_len", 128'(c_len), 128'd5);
    xpulse(4'b0000, 1'b0, 1'b1);
    xpulse(4'b0000, 1'b1, 1'b0);
    repeat (6) xpulse(4'b0000, 1'b0, 1'b0);
    check("w_win", 128'({ww, wm}), 128'b10);
    check("w_len", 128'(w_len), 128'd4);
    check("w_loc", 128'(w_loc), 128'h86878889);
    check("c_first", 128'(c_loc[7:0]), 128'h89);
    xpulse(4'b1000, 1'b1, 1'b0);
    repeat (6) xpulse(4'b0000, 1'b0, 1'b0);
    xpulse(4'b0010, 1'b1, 1'b0);
    repeat (6) xpulse(4'b0000, 1'b0, 1'b0);
    xpulse(4'b0100, 1'b1, 1'b0);
    repeat (6) xpulse(4'b0000, 1'b0, 1'b0);
    check("c_lose", 128'({cl, cm}), 128'b10);
    check("c_lose_loc", 128'(c_loc[39:0]), 128'h8788897978);
    xpulse(4'b0000, 1'b1, 1'b0);
    repeat (6) xpulse(4'b0000, 1'b0, 1'b0);
    check("c_tick_in_ql", 128'({cl, cc}), 128'b10);
    xpulse(4'b0000, 1'b0, 1'b1);
    xpulse(4'b0000, 1'b0, 1'b0);
    check("w_restart", 128'({wi, w_len, w_food}), {119'd0, 1'b1, 3'd3, 8'h89});
    check("w_restart_loc", 128'(w_loc), 128'hFF868788);
    check("c_restart", 128'({ci, c_len}), {122'd0, 1'b1, 5'd5});

    repeat (3) @(negedge board_clk);
    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
